rvga_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit implementing the RV32M funct3 operation set over WIDTH-bit operands. It sits beside rvga_alu in the execute stage and handles MUL/DIV-class instructions. It uses a one-bit-per-cycle shift-add multiplier and a restoring divider. The pipeline stalls through a valid/ready request handshake and a valid/yumi response handshake.

---
 rtl/rvga_muldiv.sv | 138 +++++++++++++
 tb/tb_rvga_muldiv.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rvga_muldiv.sv
// Iterative RV32M-style multiply/divide: shift-add multiplier and restoring divider, one bit per cycle.
// Latency WIDTH+1 cycles (1 for divide-by-zero / signed overflow); holds result until yumi_i.
module rvga_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             v_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       op_i,
  output logic             v_o,
  output logic [WIDTH-1:0] o,
  input  logic             yumi_i
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t             r_state;
  logic               r_rdy;
  logic               r_v;
  logic               r_neg;
  logic [2:0]         r_op;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_o;
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH:0]     r_rem;

  logic               w_a_sgn, w_b_sgn, w_a_neg, w_b_neg, w_neg, w_div0, w_ovf;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag, w_spec;

  assign w_a_sgn = (op_i == 3'd1) || (op_i == 3'd2) || (op_i == 3'd4) || (op_i == 3'd6);
  assign w_b_sgn = (op_i == 3'd1) || (op_i == 3'd4) || (op_i == 3'd6);
  assign w_a_neg = w_a_sgn & a_i[WIDTH-1];
  assign w_b_neg = w_b_sgn & b_i[WIDTH-1];
  assign w_a_mag = w_a_neg ? -a_i : a_i;
  assign w_b_mag = w_b_neg ? -b_i : b_i;
  // Remainder follows the dividend's sign; everything else follows the sign product.
  assign w_neg   = (op_i == 3'd6) ? w_a_neg : (w_a_neg ^ w_b_neg);
  assign w_div0  = op_i[2] & (b_i == '0);
  assign w_ovf   = op_i[2] & ~op_i[0] & (a_i == {1'b1, {(WIDTH-1){1'b0}}}) & (&b_i);
  assign w_spec  = w_div0 ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);

  logic [WIDTH:0]     w_sum;
  logic [2*WIDTH-1:0] w_prod_nxt, w_prod_fin;
  logic [WIDTH+1:0]   w_shift, w_diff;
  logic               w_ge;
  logic [WIDTH:0]     w_rem_nxt;
  logic [WIDTH-1:0]   w_quo_nxt, w_div_fin, w_res;

  assign w_sum      = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + {1'b0, (r_prod[0] ? r_a : {WIDTH{1'b0}})};
  assign w_prod_nxt = {w_sum, r_prod[WIDTH-1:1]};
  assign w_prod_fin = r_neg ? -w_prod_nxt : w_prod_nxt;

  assign w_shift    = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_shift - {2'b00, r_b};
  assign w_ge       = ~w_diff[WIDTH+1];
  assign w_rem_nxt  = w_ge ? w_diff[WIDTH:0] : w_shift[WIDTH:0];
  assign w_quo_nxt  = {r_quo[WIDTH-2:0], w_ge};
  assign w_div_fin  = r_op[1] ? (r_neg ? -w_rem_nxt[WIDTH-1:0] : w_rem_nxt[WIDTH-1:0])
                              : (r_neg ? -w_quo_nxt : w_quo_nxt);

  // Final result is taken from the last iteration's next-state values.
  assign w_res = r_op[2] ? w_div_fin
               : ((r_op[1:0] == 2'd0) ? w_prod_fin[WIDTH-1:0] : w_prod_fin[2*WIDTH-1:WIDTH]);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state <= IDLE;
      r_rdy   <= 1'b1;
      r_v     <= 1'b0;
      r_o     <= '0;
      r_cnt   <= '0;
      r_neg   <= 1'b0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_quo   <= '0;
      r_rem   <= '0;
      r_prod  <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (v_i) begin
            r_op   <= op_i;
            r_neg  <= w_neg;
            r_a    <= w_a_mag;
            r_b    <= w_b_mag;
            r_prod <= {{WIDTH{1'b0}}, w_b_mag};
            r_rem  <= '0;
            r_quo  <= w_a_mag;
            r_rdy  <= 1'b0;
            if (w_div0 || w_ovf) begin
              r_state <= DONE;
              r_o     <= w_spec;
              r_v     <= 1'b1;
            end else begin
              r_state <= CALC;
              r_cnt   <= CNT_W'(WIDTH);
            end
          end
        end
        CALC: begin
          r_prod <= w_prod_nxt;
          r_rem  <= w_rem_nxt;
          r_quo  <= w_quo_nxt;
          r_cnt  <= r_cnt - CNT_W'(1);
          if (r_cnt == CNT_W'(1)) begin
            r_state <= DONE;
            r_o     <= w_res;
            r_v     <= 1'b1;
          end
        end
        DONE: begin
          if (yumi_i) begin
            r_state <= IDLE;
            r_v     <= 1'b0;
            r_rdy   <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_rdy   <= 1'b1;
          r_v     <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = r_rdy;
  assign v_o     = r_v;
  assign o       = r_o;
endmodule

// File: tb/tb_rvga_muldiv.sv
// Bench for rvga_muldiv at WIDTH=32 and WIDTH=8: directed vectors, hold/abort cases and random ops
// checked against an arithmetic reference model.
module tb_rvga_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        v32, y32, rdy32, vo32;
  logic [2:0]  op32;
  logic [31:0] a32, b32, o32;
  logic        v8, y8, rdy8, vo8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8, o8;

  int n_chk  = 0;
  int n_fail = 0;

  rvga_muldiv #(.WIDTH(32)) u_dut32 (
    .clk_i(clk), .reset_i(rst), .v_i(v32), .ready_o(rdy32), .a_i(a32), .b_i(b32),
    .op_i(op32), .v_o(vo32), .o(o32), .yumi_i(y32)
  );

  rvga_muldiv #(.WIDTH(8)) u_dut8 (
    .clk_i(clk), .reset_i(rst), .v_i(v8), .ready_o(rdy8), .a_i(a8), .b_i(b8),
    .op_i(op8), .v_o(vo8), .o(o8), .yumi_i(y8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference: signed/unsigned interpretation in 64-bit arithmetic, truncated to w bits.
  function automatic logic [31:0] model(input int w, input logic [2:0] op,
                                        input logic [31:0] a, input logic [31:0] b);
    longint one, mask, ua, ub, sa, sb, r, mn;
    one  = 1;
    mask = (one << w) - one;
    mn   = one << (w - 1);
    ua   = {32'b0, a} & mask;
    ub   = {32'b0, b} & mask;
    sa   = (ua ^ mn) - mn;
    sb   = (ub ^ mn) - mn;
    case (op)
      3'd0: r = ua * ub;
      3'd1: r = (sa * sb) >>> w;
      3'd2: r = (sa * ub) >>> w;
      3'd3: r = (ua * ub) >> w;
      3'd4: if (ub == 0) r = mask; else if (sa == -mn && sb == -one) r = ua; else r = sa / sb;
      3'd5: if (ub == 0) r = mask; else r = ua / ub;
      3'd6: if (ub == 0) r = ua; else if (sa == -mn && sb == -one) r = 0; else r = sa % sb;
      default: if (ub == 0) r = ua; else r = ua % ub;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic int exp_lat(input int w, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mask, mn;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    mn   = 32'd1 << (w - 1);
    if (op[2] && b == 32'd0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == mn && b == mask) return 1;
    return w + 1;
  endfunction

  function automatic logic [31:0] rnd_operand(input int w);
    logic [31:0] mask, v;
    mask = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    case ($urandom_range(0, 7))
      0:       v = 32'd0;
      1:       v = mask;
      2:       v = 32'd1 << (w - 1);
      3:       v = 32'($urandom_range(0, 15));
      default: v = $urandom & mask;
    endcase
    return v;
  endfunction

  function automatic logic cur_rdy(input bit w8); return w8 ? rdy8 : rdy32; endfunction
  function automatic logic cur_vo(input bit w8);  return w8 ? vo8 : vo32;   endfunction
  function automatic logic [31:0] cur_o(input bit w8); return w8 ? {24'b0, o8} : o32; endfunction

  task automatic drive(input bit w8, input logic v, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    if (w8) begin v8 = v; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else    begin v32 = v; op32 = op; a32 = a; b32 = b; end
  endtask

  // Present a request, wait for acceptance, then count cycles until v_o.
  task automatic issue(input bit w8, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, output logic [31:0] res, output int lat);
    int g = 0;
    drive(w8, 1'b1, op, a, b);
    while (!cur_rdy(w8) && g < 100) begin @(posedge clk); #1; g++; end
    @(posedge clk); #1;
    drive(w8, 1'b0, op, a, b);
    lat = 1;
    while (!cur_vo(w8) && lat < 100) begin @(posedge clk); #1; lat++; end
    res = cur_o(w8);
  endtask

  task automatic take(input bit w8);
    if (cur_vo(w8)) begin
      if (w8) y8 = 1'b1; else y32 = 1'b1;
      @(posedge clk); #1;
      y8 = 1'b0; y32 = 1'b0;
      chk("rdy_after_yumi", 32'(cur_rdy(w8)), 32'd1);
      chk("vo_after_yumi", 32'(cur_vo(w8)), 32'd0);
    end
  endtask

  task automatic run(input bit w8, input logic [2:0] op, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exp, input string tag);
    logic [31:0] res;
    int lat;
    issue(w8, op, a, b, res, lat);
    chk({tag, "_res"}, res, exp);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat(w8 ? 8 : 32, op, a, b)));
    take(w8);
  endtask

  always @(posedge clk) begin
    if (y32) chk("yumi32_legal", 32'(vo32), 32'd1);
    if (y8)  chk("yumi8_legal", 32'(vo8), 32'd1);
  end

  typedef struct {
    bit          w8;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t dir [23] = '{
    '{1'b0, 3'd0, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A},
    '{1'b0, 3'd1, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF},
    '{1'b0, 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
    '{1'b0, 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF},
    '{1'b0, 3'd4, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD},
    '{1'b0, 3'd6, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF},
    '{1'b0, 3'd5, 32'd100,       32'd7,         32'd14},
    '{1'b0, 3'd7, 32'd100,       32'd7,         32'd2},
    '{1'b0, 3'd5, 32'd7,         32'd0,         32'hFFFF_FFFF},
    '{1'b0, 3'd7, 32'd7,         32'd0,         32'd7},
    '{1'b0, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
    '{1'b0, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
    '{1'b1, 3'd5, 32'hFF, 32'h10, 32'h0F},
    '{1'b1, 3'd3, 32'hFF, 32'hFF, 32'hFE},
    '{1'b1, 3'd0, 32'h07, 32'h06, 32'h2A},
    '{1'b1, 3'd1, 32'hFE, 32'h03, 32'hFF},
    '{1'b1, 3'd2, 32'hFF, 32'hFF, 32'hFF},
    '{1'b1, 3'd4, 32'hF9, 32'h02, 32'hFD},
    '{1'b1, 3'd6, 32'hF9, 32'h02, 32'hFF},
    '{1'b1, 3'd5, 32'h07, 32'h00, 32'hFF},
    '{1'b1, 3'd7, 32'h07, 32'h00, 32'h07},
    '{1'b1, 3'd4, 32'h80, 32'hFF, 32'h80},
    '{1'b1, 3'd6, 32'h80, 32'hFF, 32'h00}
  };

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  op;
    int lat, seen;

    rst = 1'b1; y32 = 1'b0; y8 = 1'b0;
    drive(1'b0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1'b1, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_rdy32", 32'(rdy32), 32'd1);
    chk("rst_vo32", 32'(vo32), 32'd0);
    chk("rst_o32", o32, 32'd0);
    chk("rst_rdy8", 32'(rdy8), 32'd1);
    chk("rst_vo8", 32'(vo8), 32'd0);
    chk("rst_o8", {24'b0, o8}, 32'd0);

    for (int i = 0; i < 23; i++)
      run(dir[i].w8, dir[i].op, dir[i].a, dir[i].b, dir[i].exp, $sformatf("dir%0d", i));

    // Result held while consumer stalls; competing request must wait.
    issue(1'b0, 3'd0, 32'd3, 32'd5, res, lat);
    chk("hold_first_res", res, 32'd15);
    drive(1'b0, 1'b1, 3'd5, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_vo", 32'(vo32), 32'd1);
      chk("hold_o", o32, 32'd15);
      chk("hold_rdy", 32'(rdy32), 32'd0);
    end
    y32 = 1'b1;
    @(posedge clk); #1;
    y32 = 1'b0;
    chk("hold_rdy_after_yumi", 32'(rdy32), 32'd1);
    run(1'b0, 3'd5, 32'd100, 32'd7, 32'd14, "hold_next");

    // Abort a divide at iteration 16.
    drive(1'b0, 1'b1, 3'd4, 32'h1234_5678, 32'd3);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 3'd4, 32'h1234_5678, 32'd3);
    repeat (15) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_rdy", 32'(rdy32), 32'd1);
    chk("abort_vo", 32'(vo32), 32'd0);
    chk("abort_o", o32, 32'd0);
    seen = 0;
    repeat (40) begin @(posedge clk); #1; if (vo32) seen++; end
    chk("abort_no_vo", 32'(seen), 32'd0);
    run(1'b0, 3'd0, 32'd3, 32'd5, 32'd15, "after_abort");

    for (int i = 0; i < 120; i++) begin
      op = 3'($urandom_range(0, 7));
      a = rnd_operand(32);
      b = rnd_operand(32);
      run(1'b0, op, a, b, model(32, op, a, b), $sformatf("rnd32_%0d_op%0d", i, op));
    end
    for (int i = 0; i < 200; i++) begin
      op = 3'($urandom_range(0, 7));
      a = rnd_operand(8);
      b = rnd_operand(8);
      run(1'b1, op, a, b, model(8, op, a, b), $sformatf("rnd8_%0d_op%0d", i, op));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
